// File: rtl/uart_tx_fifo.sv
// Byte FIFO and flow control in front of a UART transmitter.
// Issues one DV pulse per byte and waits for the transmitter's Done before issuing the next.
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             i_Clock,
   input  logic             i_Rst,
   input  logic             i_Wr_DV,
   input  logic [7:0]       i_Wr_Byte,
   output logic             o_Full,
   output logic             o_Empty,
   output logic [CNT_W-1:0] o_Count,
   output logic             o_Overflow,
   output logic             o_TX_DV,
   output logic [7:0]       o_TX_Byte,
   input  logic             i_TX_Active,
   input  logic             i_TX_Done
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_DONE, S_GAP} state_t;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, empty_q, overflow_q, tx_dv_q;
   logic [7:0]       tx_byte_q;
   state_t           state_q, state_d;
   logic             wr_en, rd_en;

   // Full and empty are the registered flags, so same-cycle read/write never interact.
   assign wr_en = i_Wr_DV && !full_q;

   always_comb begin
      state_d = state_q;
      rd_en   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!empty_q && !i_TX_Active) begin
               rd_en   = 1'b1;
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (i_TX_Done) state_d = S_GAP;
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_Clock) begin
      if (i_Rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         tx_dv_q    <= 1'b0;
         tx_byte_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         full_q     <= (count_d == CNT_W'(DEPTH));
         empty_q    <= (count_d == '0);
         overflow_q <= i_Wr_DV && full_q;
         tx_dv_q    <= rd_en;
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            tx_byte_q <= mem[rd_ptr_q];
         end
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge i_Clock) begin
      if (wr_en && !i_Rst) mem[wr_ptr_q] <= i_Wr_Byte;
   end

   assign o_Full     = full_q;
   assign o_Empty    = empty_q;
   assign o_Count    = count_q;
   assign o_Overflow = overflow_q;
   assign o_TX_DV    = tx_dv_q;
   assign o_TX_Byte  = tx_byte_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and flow-control stage that sits directly upstream of the UART transmitter.
- Accepts bytes from the host logic in single-cycle write strobes and stores them in a DEPTH-entry FIFO.
- Presents bytes one at a time to the transmitter on its DV/Byte input and waits for the transmitter's Done pulse before issuing the next.
- Lets software or upstream logic burst data without tracking transmitter timing.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived, not overridden)

Ports:
i_Clock  in  1  system clock
i_Rst  in  1  synchronous active-high reset
i_Wr_DV  in  1  write strobe; byte on i_Wr_Byte captured this cycle if not full
i_Wr_Byte  in  8  byte to enqueue
o_Full  out  1  FIFO holds DEPTH bytes
o_Empty  out  1  FIFO holds 0 bytes
o_Count  out  CNT_W  current occupancy, 0..DEPTH
o_Overflow  out  1  one-cycle pulse: write attempted while full, byte dropped
o_TX_DV  out  1  one-cycle pulse to transmitter start input
o_TX_Byte  out  8  byte for transmitter, valid while o_TX_DV=1 and held afterwards
i_TX_Active  in  1  transmitter busy flag
i_TX_Done  in  1  transmitter done flag (high ≥1 cycle after stop bit ends)

Behaviour:
- One clock domain: i_Clock. Reset: i_Rst, synchronous, active-high, dominates all other inputs.
- Reset values: o_Full=0, o_Empty=1, o_Count=0, o_Overflow=0, o_TX_DV=0, o_TX_Byte=8'h00. Read and write pointers are 0; FSM is S_IDLE. Storage contents are not reset.
- Storage: DEPTH x 8 register array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write: on a cycle with i_Wr_DV=1 and o_Full=0, mem[wr_ptr] is written and wr_ptr increments.
  - If o_Full=1, the byte is dropped and o_Overflow=1 on the next cycle for exactly one cycle.
  - Full is judged on the registered flag, so a same-cycle read does not make room.
- Read: performed only by the FSM, only when o_Empty=0. Empty is judged on the registered flag, so a byte written this cycle is not readable until the next.
- Count: simultaneous accepted write and read leaves o_Count unchanged. Otherwise +1 per write and -1 per read.
  - o_Full = (o_Count==DEPTH); o_Empty = (o_Count==0). Both are registered and updated with the count.
- FSM states:
  - S_IDLE: if o_Empty=0 and i_TX_Active=0, then o_TX_Byte<=mem[rd_ptr], o_TX_DV<=1, rd_ptr++, go S_WAIT_DONE. Otherwise stay.
  - S_WAIT_DONE: o_TX_DV<=0. When i_TX_Done=1, go S_GAP.
  - S_GAP: one cycle, then S_IDLE. i_TX_Done is ignored here; the transmitter holds Done through its cleanup and clears it on returning to idle.
- o_TX_DV is high exactly one cycle per byte. o_TX_Byte is stable from that cycle until the next DV.
- Latency: write sampled at edge N into an empty FIFO with idle transmitter gives o_TX_DV high in the cycle after edge N+1 (2 cycles).
- Back-to-back: next o_TX_DV is asserted 3 cycles after the first cycle i_TX_Done=1, provided the FIFO is non-empty.
- Reset mid-transfer: FIFO is flushed and the FSM returns to S_IDLE. The transmitter must be reset by the same event, because no Done will arrive for the aborted byte.
- Bytes leave in write order. No byte is duplicated or skipped across pointer wrap.

Test Plan:
- Reset, then write 8'hA5 once, transmitter model with 10-cycle frame: o_TX_DV one pulse 2 cycles after write with o_TX_Byte=8'hA5; o_Count goes 0→1→0; o_Empty returns 1.
- DEPTH=4: write 8'h01..8'h04 on consecutive cycles while transmitter held Active: o_Full=1, o_Count=4. A 5th write of 8'h05 gives an o_Overflow single-cycle pulse and the byte is not sent.
- Burst 8'h10..8'h15 (DEPTH=4, paced by o_Full), drain through real transmitter at CLKS_PER_BIT=4: serial output decodes to 10,11,12,13,14,15 in order, covering pointer wrap.
- Write on same cycle the FSM reads with o_Count=2: o_Count stays 2, and the next o_TX_Byte is the older entry.
- i_TX_Done held high 2 cycles: exactly one new o_TX_DV follows, 3 cycles after Done rises.
- Assert i_Rst for 1 cycle during S_WAIT_DONE with 3 bytes queued: o_Count=0, o_Empty=1, o_TX_DV=0, and no further DV after reset releases until a new write.
